// File: rtl/display_write_sink.sv
// Display store sink: queues CPU pixel writes and drains them into the framebuffer port.
// A full-screen clear sweep runs after reset and on request, after queued writes drain.
module display_write_sink #(
    parameter int         FIFO_DEPTH  = 4,
    parameter logic [2:0] CLEAR_COLOR = 3'b000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        display_we,
    input  logic [13:0] display_data,
    input  logic        clear_req,
    output logic        fb_we,
    output logic [10:0] fb_addr,
    output logic [2:0]  fb_color,
    input  logic        fb_ready,
    output logic        busy,
    output logic        overflow
);

    // state | meaning
    // INIT  | one idle cycle after reset, no framebuffer writes
    // CLEAR | sweeping all 2048 addresses with CLEAR_COLOR
    // RUN   | draining queued CPU writes; waits for a drained FIFO before a requested clear
    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [1:0]    state_q, state_d;
    logic [10:0]   sweep_q, sweep_d;
    logic          pend_q, pend_d;
    logic          ovf_q, ovf_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [13:0]   mem_q [FIFO_DEPTH];

    logic        fifo_empty;
    logic        fifo_full;
    logic [13:0] head;
    logic        accept;
    logic        pop;
    logic        push;
    logic        drop;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == (AW+1)'(FIFO_DEPTH));
    assign head       = mem_q[rd_ptr_q];

    always_comb begin
        fb_we    = 1'b0;
        fb_addr  = '0;
        fb_color = '0;
        case (state_q)
            ST_CLEAR: begin
                fb_we    = 1'b1;
                fb_addr  = sweep_q;
                fb_color = CLEAR_COLOR;
            end
            ST_RUN: begin
                if (!fifo_empty) begin
                    fb_we    = 1'b1;
                    fb_addr  = head[10:0];
                    fb_color = head[13:11];
                end
            end
            default: begin
                fb_we = 1'b0;
            end
        endcase
    end

    assign accept = fb_we && fb_ready;
    assign pop    = (state_q == ST_RUN) && accept;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign push   = display_we && (!fifo_full || pop);
    assign drop   = display_we && !push;

    assign wr_ptr_d = wr_ptr_q + AW'(push);
    assign rd_ptr_d = rd_ptr_q + AW'(pop);
    assign count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
    assign ovf_d    = ovf_q | drop;

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        pend_d  = pend_q;
        case (state_q)
            ST_INIT: begin
                state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                if (accept) begin
                    sweep_d = sweep_q + 11'd1;
                    if (sweep_q == '1) begin
                        pend_d  = 1'b0;
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (clear_req) begin
                    pend_d = 1'b1;
                end
                if (pend_q && (count_d == '0)) begin
                    state_d = ST_CLEAR;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_INIT;
            sweep_q  <= '0;
            pend_q   <= 1'b0;
            ovf_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            sweep_q  <= sweep_d;
            pend_q   <= pend_d;
            ovf_q    <= ovf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= display_data;
        end
    end

    assign busy     = (state_q != ST_RUN) || pend_q || !fifo_empty;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_display_write_sink.sv
// Directed bench for display_write_sink: reset sweep, single write, backpressure,
// full-with-pop, clear request with queued data, clear latency, mid-sweep reset.
module tb_display_write_sink;

    localparam logic [2:0] CLR = 3'b110;

    logic        clk;
    logic        rst_n;
    logic        display_we;
    logic [13:0] display_data;
    logic        clear_req;
    logic        fb_we;
    logic [10:0] fb_addr;
    logic [2:0]  fb_color;
    logic        fb_ready;
    logic        busy;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    display_write_sink #(.FIFO_DEPTH(4), .CLEAR_COLOR(CLR)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .display_we   (display_we),
        .display_data (display_data),
        .clear_req    (clear_req),
        .fb_we        (fb_we),
        .fb_addr      (fb_addr),
        .fb_color     (fb_color),
        .fb_ready     (fb_ready),
        .busy         (busy),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [13:0] mk(input logic [2:0] c, input logic [5:0] r, input logic [4:0] col);
        return {c, r, col};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [13:0] d);
        display_we   = 1'b1;
        display_data = d;
        step();
        display_we   = 1'b0;
    endtask

    task automatic check_head(input string tag, input logic [13:0] d);
        check_eq({tag, "_we"}, fb_we, 1);
        check_eq({tag, "_addr"}, fb_addr, d[10:0]);
        check_eq({tag, "_color"}, fb_color, d[13:11]);
    endtask

    // Leaves the DUT in its first CLEAR cycle (address 0 presented).
    task automatic do_reset();
        display_we = 1'b0;
        clear_req  = 1'b0;
        rst_n      = 1'b0;
        #1;
        check_eq("rst_we", fb_we, 0);
        check_eq("rst_addr", fb_addr, 0);
        check_eq("rst_color", fb_color, 0);
        check_eq("rst_busy", busy, 1);
        check_eq("rst_ovf", overflow, 0);
        step();
        rst_n = 1'b1;
        check_eq("init_we", fb_we, 0);
        check_eq("init_busy", busy, 1);
        step();
    endtask

    task automatic sweep_check(input int push_at, input logic [13:0] pd);
        for (int i = 0; i < 2048; i++) begin
            check_eq("sweep_we", fb_we, 1);
            check_eq("sweep_addr", fb_addr, i[10:0]);
            check_eq("sweep_color", fb_color, CLR);
            if (i == 1024) check_eq("sweep_busy", busy, 1);
            if (i == push_at) begin
                display_we   = 1'b1;
                display_data = pd;
            end else begin
                display_we = 1'b0;
            end
            step();
        end
        display_we = 1'b0;
    endtask

    logic [13:0] vec [5];
    logic [13:0] g;

    initial begin
        clk          = 1'b0;
        rst_n        = 1'b1;
        display_we   = 1'b0;
        display_data = '0;
        clear_req    = 1'b0;
        fb_ready     = 1'b1;
        #2;

        // Reset sweep
        do_reset();
        sweep_check(-1, '0);
        check_eq("run_we", fb_we, 0);
        check_eq("run_busy", busy, 0);
        check_eq("run_ovf", overflow, 0);

        // Single write in RUN
        push(14'b101_000011_00101);
        check_eq("single_we", fb_we, 1);
        check_eq("single_addr", fb_addr, 11'b000011_00101);
        check_eq("single_color", fb_color, 3'b101);
        step();
        check_eq("single_done_we", fb_we, 0);
        check_eq("single_done_busy", busy, 0);

        // Backpressure: four held, fifth dropped
        for (int k = 0; k < 5; k++) vec[k] = mk(3'(k + 1), 6'(k * 7 + 2), 5'(31 - k));
        fb_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            push(vec[k]);
            check_head("bp_hold", vec[0]);
            check_eq("bp_ovf", overflow, 0);
        end
        push(vec[4]);
        check_eq("bp_ovf_set", overflow, 1);
        check_head("bp_hold5", vec[0]);
        fb_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check_head("bp_drain", vec[k]);
            step();
        end
        check_eq("bp_empty_we", fb_we, 0);
        check_eq("bp_ovf_sticky", overflow, 1);

        // Full FIFO plus simultaneous pop
        do_reset();
        sweep_check(-1, '0);
        for (int k = 0; k < 5; k++) vec[k] = mk(3'(7 - k), 6'(63 - k * 5), 5'(k * 6 + 1));
        fb_ready = 1'b0;
        for (int k = 0; k < 4; k++) push(vec[k]);
        check_head("full_head", vec[0]);
        fb_ready     = 1'b1;
        display_we   = 1'b1;
        display_data = vec[4];
        step();
        display_we = 1'b0;
        check_eq("full_pop_ovf", overflow, 0);
        for (int k = 1; k < 5; k++) begin
            check_head("full_drain", vec[k]);
            step();
        end
        check_eq("full_empty_we", fb_we, 0);
        check_eq("full_ovf_final", overflow, 0);

        // Clear request with queued data, write pushed mid-sweep
        vec[0] = mk(3'b011, 6'd40, 5'd17);
        vec[1] = mk(3'b100, 6'd41, 5'd18);
        g      = mk(3'b001, 6'd55, 5'd9);
        fb_ready = 1'b0;
        push(vec[0]);
        push(vec[1]);
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        check_eq("cq_busy", busy, 1);
        check_head("cq_hold", vec[0]);
        fb_ready = 1'b1;
        check_head("cq_drain0", vec[0]);
        step();
        check_head("cq_drain1", vec[1]);
        step();
        sweep_check(500, g);
        check_head("cq_after_sweep", g);
        step();
        check_eq("cq_end_we", fb_we, 0);
        check_eq("cq_end_busy", busy, 0);

        // clear_req latency with empty FIFO
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        check_eq("clat_we", fb_we, 0);
        check_eq("clat_busy", busy, 1);
        step();
        sweep_check(-1, '0);
        check_eq("clat_end_we", fb_we, 0);
        check_eq("clat_end_busy", busy, 0);

        // Mid-sweep reset, with an overflow forced during the sweep
        do_reset();
        for (int i = 0; i < 1000; i++) begin
            if (i >= 990 && i < 995) begin
                display_we   = 1'b1;
                display_data = mk(3'b111, 6'(i - 990), 5'd2);
            end else begin
                display_we = 1'b0;
            end
            step();
        end
        display_we = 1'b0;
        check_eq("mid_addr", fb_addr, 1000);
        check_eq("mid_ovf", overflow, 1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_we", fb_we, 0);
        check_eq("mid_rst_ovf", overflow, 0);
        do_reset();
        sweep_check(-1, '0);
        check_eq("mid_end_we", fb_we, 0);
        check_eq("mid_end_busy", busy, 0);
        check_eq("mid_end_ovf", overflow, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
